// File: rtl/conv_pkg.sv
// conv_pkg: shared widths, the kernel type and the arithmetic helpers used by
// the 3x3 convolution pipeline.
//   kernel_t    : [r][c] signed 8-bit coefficients, r/c index 0 = offset -1.
//   clip_shift  : limits a signed shift request to the 0..15 range.
//   clamp_pix   : saturates a signed accumulator value into 0..255.
package conv_pkg;

  localparam int unsigned KERNEL_SIZE  = 3;
  localparam int unsigned PIX_WIDTH    = 8;
  localparam int unsigned COEFF_WIDTH  = 8;
  localparam int unsigned ACC_WIDTH    = 20;
  localparam int unsigned PIPE_LATENCY = 4;
  // zero-extended pixel (9b signed) times coefficient (8b signed)
  localparam int unsigned PROD_WIDTH   = PIX_WIDTH + 1 + COEFF_WIDTH;

  typedef logic signed [2:0][2:0][7:0] kernel_t;

  function automatic logic [3:0] clip_shift(input logic signed [7:0] s);
    if (s < 8'sd0)
      return 4'd0;
    else if (s > 8'sd15)
      return 4'd15;
    else
      return s[3:0];
  endfunction

  function automatic logic [PIX_WIDTH-1:0] clamp_pix(input logic signed [ACC_WIDTH-1:0] v);
    if (v < 20'sd0)
      return '0;
    else if (v > 20'sd255)
      return '1;
    else
      return v[PIX_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/convolution_line_buffer.sv
// line_buffer: one DEPTH x WIDTH line RAM with a single address port.
// Read is registered and read-first, so a write and a read of the same
// address in one cycle returns the previous line's pixel.
//   clk_i   : clock
//   we_i    : write enable
//   addr_i  : column address (shared by read and write)
//   wdata_i : pixel to store
//   rdata_o : registered read data (old contents at addr_i)
module line_buffer #(
  parameter int unsigned DEPTH = 320,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i)
      mem_q[addr_i] <= wdata_i;
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/convolution.sv
// convolution: 3x3 signed-kernel filter over a raster-ordered 8-bit pixel
// stream. Four register stages (line read, window, products, sum/shift/clamp)
// give a fixed 4-cycle latency; one output per valid input whose centre
// (hcount_in-1, vcount_in-1) is inside the frame.
//   clk_in, rst_in         : clock, synchronous active-high reset
//   data_in_valid          : input pixel/coordinates valid
//   pixel_data_in          : unsigned pixel
//   hcount_in, vcount_in   : input column / row
//   coeffs, shift          : kernel and right shift, captured at pixel (0,0)
//   data_out_valid         : one-cycle pulse per filtered pixel
//   pixel_data_out         : clamped filtered pixel
//   hcount_out, vcount_out : centre coordinates of the filtered pixel
module convolution
  import conv_pkg::*;
#(
  parameter int unsigned HRES = 320,
  parameter int unsigned VRES = 240
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        data_in_valid,
  input  logic [7:0]  pixel_data_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  kernel_t     coeffs,
  input  logic signed [7:0] shift,
  output logic        data_out_valid,
  output logic [7:0]  pixel_data_out,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out
);

  localparam int unsigned AW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int unsigned PW = PROD_WIDTH;

  logic in_ok, is_origin;
  logic [7:0] rd0, rd1;

  logic    line_idx_q;
  kernel_t cap_kern_q, kern_q;
  logic signed [7:0] cap_shift_q, shift_q;

  // S1
  logic        s1_vld_q, s1_emit_q, s1_first_q, s1_sel_q;
  logic [7:0]  s1_pix_q;
  logic [10:0] s1_h_q;
  logic [9:0]  s1_v_q;
  // S2
  logic [7:0]  win_q [KERNEL_SIZE][KERNEL_SIZE];
  logic        s2_emit_q, s2_first_q;
  logic [10:0] s2_ch_q;
  logic [9:0]  s2_cv_q;
  // S3
  logic signed [PW-1:0] prod_d [KERNEL_SIZE][KERNEL_SIZE];
  logic signed [PW-1:0] prod_q [KERNEL_SIZE][KERNEL_SIZE];
  logic        s3_emit_q;
  logic [10:0] s3_ch_q;
  logic [9:0]  s3_cv_q;
  // S4
  logic signed [ACC_WIDTH-1:0] acc_d, shifted_d;
  logic [7:0] res_d;

  assign in_ok     = data_in_valid && (hcount_in < 11'(HRES)) && (vcount_in < 10'(VRES));
  assign is_origin = (hcount_in == '0) && (vcount_in == '0);

  // The buffer being written holds row v-2; the other holds row v-1.
  line_buffer #(.DEPTH(HRES), .WIDTH(PIX_WIDTH), .AW(AW)) u_lb0 (
    .clk_i   (clk_in),
    .we_i    (in_ok && !line_idx_q),
    .addr_i  (hcount_in[AW-1:0]),
    .wdata_i (pixel_data_in),
    .rdata_o (rd0)
  );

  line_buffer #(.DEPTH(HRES), .WIDTH(PIX_WIDTH), .AW(AW)) u_lb1 (
    .clk_i   (clk_in),
    .we_i    (in_ok && line_idx_q),
    .addr_i  (hcount_in[AW-1:0]),
    .wdata_i (pixel_data_in),
    .rdata_o (rd1)
  );

  // Zero padding on the top row / left column is applied from the centre.
  always_comb begin
    logic [7:0] px;
    logic signed [PW-1:0] pe, ce;
    px = '0;
    pe = '0;
    ce = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
      for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
        px = win_q[r][c];
        if ((r == 0 && s2_cv_q == '0) || (c == 0 && s2_ch_q == '0))
          px = '0;
        pe = PW'(signed'({1'b0, px}));
        ce = PW'(signed'(kern_q[r][c]));
        prod_d[r][c] = pe * ce;
      end
    end
  end

  always_comb begin
    acc_d = '0;
    for (int unsigned r = 0; r < KERNEL_SIZE; r++)
      for (int unsigned c = 0; c < KERNEL_SIZE; c++)
        acc_d = acc_d + ACC_WIDTH'(prod_q[r][c]);
    shifted_d = acc_d >>> clip_shift(shift_q);
    res_d     = clamp_pix(shifted_d);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_idx_q     <= 1'b0;
      cap_kern_q     <= '0;
      cap_shift_q    <= '0;
      kern_q         <= '0;
      shift_q        <= '0;
      s1_vld_q       <= 1'b0;
      s1_emit_q      <= 1'b0;
      s1_first_q     <= 1'b0;
      s1_sel_q       <= 1'b0;
      s1_pix_q       <= '0;
      s1_h_q         <= '0;
      s1_v_q         <= '0;
      s2_emit_q      <= 1'b0;
      s2_first_q     <= 1'b0;
      s2_ch_q        <= '0;
      s2_cv_q        <= '0;
      s3_emit_q      <= 1'b0;
      s3_ch_q        <= '0;
      s3_cv_q        <= '0;
      for (int unsigned r = 0; r < KERNEL_SIZE; r++)
        for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
          win_q[r][c]  <= '0;
          prod_q[r][c] <= '0;
        end
      data_out_valid <= 1'b0;
      pixel_data_out <= '0;
      hcount_out     <= '0;
      vcount_out     <= '0;
    end else begin
      // S1: register input; RAM read happens in the line buffers.
      s1_vld_q   <= in_ok;
      s1_emit_q  <= in_ok && (hcount_in != '0) && (vcount_in != '0);
      s1_first_q <= in_ok && is_origin;
      if (in_ok) begin
        s1_pix_q <= pixel_data_in;
        s1_h_q   <= hcount_in;
        s1_v_q   <= vcount_in;
        s1_sel_q <= line_idx_q;
        if (is_origin) begin
          cap_kern_q  <= coeffs;
          cap_shift_q <= shift;
        end
        if (hcount_in == 11'(HRES - 1))
          line_idx_q <= !line_idx_q;
      end

      // S2: window shift. The kernel moves into use when the frame's first
      // pixel reaches the product stage, so the previous frame's tail still
      // sees its own kernel even with back-to-back frames.
      s2_emit_q  <= s1_emit_q;
      s2_first_q <= s1_first_q;
      if (s1_vld_q) begin
        for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= s1_sel_q ? rd1 : rd0;
        win_q[1][2] <= s1_sel_q ? rd0 : rd1;
        win_q[2][2] <= s1_pix_q;
        s2_ch_q     <= s1_h_q - 11'd1;
        s2_cv_q     <= s1_v_q - 10'd1;
        if (s1_first_q)
          kern_q <= cap_kern_q;
      end

      // S3: products (shift likewise follows its frame one stage later).
      s3_emit_q <= s2_emit_q;
      if (s2_first_q)
        shift_q <= cap_shift_q;
      if (s2_emit_q) begin
        for (int unsigned r = 0; r < KERNEL_SIZE; r++)
          for (int unsigned c = 0; c < KERNEL_SIZE; c++)
            prod_q[r][c] <= prod_d[r][c];
        s3_ch_q <= s2_ch_q;
        s3_cv_q <= s2_cv_q;
      end

      // S4: sum/shift/clamp; outputs hold between valid pulses.
      data_out_valid <= s3_emit_q;
      if (s3_emit_q) begin
        pixel_data_out <= res_d;
        hcount_out     <= s3_ch_q;
        vcount_out     <= s3_cv_q;
      end
    end
  end

endmodule

// File: tb/tb_convolution.sv
// tb_convolution: scoreboard bench for the convolution filter on an 8x6
// frame. Expected pixels come from a direct 3x3 convolution of the frame the
// bench drives, using the kernel in force at that frame's first pixel.
module tb_convolution;
  import conv_pkg::*;

  localparam int H = 8;
  localparam int V = 6;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        data_in_valid;
  logic [7:0]  pixel_data_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  kernel_t     coeffs;
  logic signed [7:0] shift;
  logic        data_out_valid;
  logic [7:0]  pixel_data_out;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;

  always #5 clk_in = ~clk_in;

  convolution #(.HRES(H), .VRES(V)) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .data_in_valid  (data_in_valid),
    .pixel_data_in  (pixel_data_in),
    .hcount_in      (hcount_in),
    .vcount_in      (vcount_in),
    .coeffs         (coeffs),
    .shift          (shift),
    .data_out_valid (data_out_valid),
    .pixel_data_out (pixel_data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out)
  );

  typedef struct {
    int h;
    int v;
    int pix;
    int cyc;
  } exp_t;

  exp_t    sb[$];
  int      checks = 0;
  int      errors = 0;
  int      cyc = 0;
  int      out_count = 0;
  int      img[V][H];
  kernel_t fk;
  int      fsh;

  int gauss[9] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
  int lap[9]   = '{-1, -1, -1, -1, 8, -1, -1, -1, -1};
  int zeros[9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

  always @(posedge clk_in) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_kernel(input int k[9], input int sh);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        fk[r][c] = 8'(k[r*3+c]);
    fsh = sh;
  endtask

  task automatic fill_const(input int val);
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = val;
  endtask

  task automatic fill_impulse(input int val, input int px, input int py);
    fill_const(0);
    img[py][px] = val;
  endtask

  function automatic int model(input int x, input int y);
    int acc, sh, yy, xx;
    acc = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        yy = y - 1 + r;
        xx = x - 1 + c;
        if (yy >= 0 && xx >= 0)
          acc += int'($signed(fk[r][c])) * img[yy][xx];
      end
    sh = (fsh < 0) ? 0 : ((fsh > 15) ? 15 : fsh);
    acc = acc >>> sh;
    if (acc < 0) acc = 0;
    if (acc > 255) acc = 255;
    return acc;
  endfunction

  // Drives up to npix pixels of img in raster order, optionally with idle
  // gaps and with the coeffs/shift inputs zeroed part-way through.
  task automatic drive_frame(input int gap_max, input bit mid_change, input int npix);
    int n;
    exp_t e;
    n = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (n == npix) return;
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk_in);
          data_in_valid = 1'b0;
        end
        @(negedge clk_in);
        if (x == 0 && y == 0) begin
          coeffs = fk;
          shift  = 8'(fsh);
        end
        if (mid_change && x == 0 && y == 2) begin
          coeffs = '0;
          shift  = '0;
        end
        data_in_valid = 1'b1;
        pixel_data_in = 8'(img[y][x]);
        hcount_in     = 11'(x);
        vcount_in     = 10'(y);
        if (x >= 1 && y >= 1) begin
          e.h   = x - 1;
          e.v   = y - 1;
          e.pix = model(x - 1, y - 1);
          e.cyc = cyc + 4;
          sb.push_back(e);
        end
        n++;
      end
    end
  endtask

  task automatic drain(input int nframes);
    @(negedge clk_in);
    data_in_valid = 1'b0;
    repeat (10) @(negedge clk_in);
    check("pending", sb.size(), 0);
    check("out_count", out_count, nframes * (H - 1) * (V - 1));
    sb.delete();
    out_count = 0;
  endtask

  always @(negedge clk_in) begin
    if (!rst_in && data_out_valid) begin
      out_count++;
      if (sb.size() == 0) begin
        check("unexpected_out", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("pix(%0d,%0d)", e.h, e.v), pixel_data_out, e.pix);
        check("hcount", hcount_out, e.h);
        check("vcount", vcount_out, e.v);
        check($sformatf("latency(%0d,%0d)", e.h, e.v), cyc, e.cyc);
      end
    end
  end

  initial begin
    rst_in        = 1'b1;
    data_in_valid = 1'b0;
    pixel_data_in = '0;
    hcount_in     = '0;
    vcount_in     = '0;
    coeffs        = '0;
    shift         = '0;
    repeat (3) @(negedge clk_in);
    check("rst_valid", data_out_valid, 0);
    check("rst_pix", pixel_data_out, 0);
    check("rst_h", hcount_out, 0);
    check("rst_v", vcount_out, 0);
    rst_in = 1'b0;

    // constant field, Gaussian
    fill_const(100);
    set_kernel(gauss, 4);
    drive_frame(0, 1'b0, H * V);
    drain(1);

    // Gaussian impulse
    fill_impulse(255, 3, 3);
    drive_frame(0, 1'b0, H * V);
    drain(1);

    // Laplacian impulse with clamping both ways
    set_kernel(lap, 0);
    drive_frame(0, 1'b0, H * V);
    drain(1);

    // kernel change mid-frame, then back-to-back frame with zero kernel
    fill_const(100);
    set_kernel(gauss, 4);
    drive_frame(0, 1'b1, H * V);
    set_kernel(zeros, 0);
    drive_frame(0, 1'b0, H * V);
    drain(2);

    // random idle gaps, random image and impulse
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        img[y][x] = $urandom_range(0, 255);
    set_kernel(gauss, 4);
    drive_frame(3, 1'b0, H * V);
    fill_impulse(255, 3, 3);
    drive_frame(3, 1'b0, H * V);
    drain(2);

    // reset in the middle of a frame, then a clean frame
    fill_const(100);
    drive_frame(0, 1'b0, 20);
    @(negedge clk_in);
    rst_in        = 1'b1;
    data_in_valid = 1'b0;
    @(posedge clk_in);
    #1;
    check("midrst_valid", data_out_valid, 0);
    check("midrst_pix", pixel_data_out, 0);
    check("midrst_h", hcount_out, 0);
    check("midrst_v", vcount_out, 0);
    sb.delete();
    @(negedge clk_in);
    rst_in    = 1'b0;
    out_count = 0;
    set_kernel(gauss, 4);
    drive_frame(1, 1'b0, H * V);
    drain(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/convolution.md
Name: convolution

Overview:
- Downstream consumer of the kernel-coefficient block. Applies its 3x3 signed kernel and right-shift to a raster-ordered 8-bit single-channel pixel stream.
- Contains two line buffers and a 3x3 window. Emits one filtered pixel per valid input, together with that pixel's centre coordinates.
- Sits between the camera/pixel pipeline and the thresholding/tracking stages.

Parameters:
- HRES, 320, active pixels per line.
- VRES, 240, active lines per frame.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- data_in_valid  input  1  pixel_data_in/hcount_in/vcount_in valid this cycle.
- pixel_data_in  input  8  unsigned pixel.
- hcount_in  input  11  input column, 0..HRES-1.
- vcount_in  input  10  input row, 0..VRES-1.
- coeffs  input  [2:0][2:0][7:0] signed  kernel; [r][c], r = row offset -1..+1 (0 = top), c = column offset -1..+1 (0 = left).
- shift  input  8 signed  arithmetic right-shift amount.
- data_out_valid  output  1  output pixel valid.
- pixel_data_out  output  8  filtered unsigned pixel.
- hcount_out  output  11  centre column of output pixel.
- vcount_out  output  10  centre row of output pixel.

Behaviour:
- Reset: all outputs 0; valid pipeline cleared; line-write index 0; window registers 0; latched kernel/shift 0. Line-buffer RAM contents are not cleared. The first full frame after reset is correct.
- Kernel latch: coeffs and shift are captured only on a valid input at (0,0). Mid-frame changes take effect at the next frame start.
- Line buffers: two HRES x 8 RAMs, rotated.
  - On each valid input, the pixel at hcount_in is read from both buffers (rows v-1, v-2) and the current pixel is written to the current buffer.
  - Index toggles after a valid write at hcount_in == HRES-1.
- Window: shifts left by one column on valid input only; the new right column is {v-2, v-1, v}. Invalid cycles leave the window unchanged. Gaps in data_in_valid are permitted anywhere.
- Output:
  - Produced for inputs with hcount_in >= 1 and vcount_in >= 1. Centre = (hcount_in-1, vcount_in-1).
  - Last column and last row centres are never emitted, giving (HRES-1) x (VRES-1) outputs per frame.
  - Zero padding: neighbours at column -1 or row -1 contribute 0, decided from the centre coordinate.
- Arithmetic:
  - Pixel zero-extended to signed 9 bits.
  - Nine signed products summed into a signed 20-bit accumulator.
  - Arithmetic right shift by shift[3:0]; shift < 0 treated as 0, shift > 15 treated as 15.
  - Result < 0 clamps to 0; result > 255 clamps to 255.
- Latency: exactly 4 cycles from the valid input cycle to data_out_valid, fixed regardless of gaps.
  - S1: RAM read/register input.
  - S2: window update.
  - S3: products registered.
  - S4: sum, shift, clamp registered to outputs.
  - hcount/vcount are pipelined alongside.
- Pipeline advances every cycle; no backpressure. data_out_valid is high for exactly one cycle per qualifying input.
- Reset mid-frame: data_out_valid is 0 on the cycle after rst_in is sampled. In-flight pixels are discarded.
- Outputs hold their last value while data_out_valid is 0.

Decomposition:
- Package conv_pkg:
  - KERNEL_SIZE = 3, PIX_WIDTH = 8, COEFF_WIDTH = 8, ACC_WIDTH = 20, PIPE_LATENCY = 4.
  - kernel_t typedef: [2:0][2:0][7:0] signed.
- Sub-module line_buffer: one single-port-write/registered-read HRES x 8 RAM. Instantiated twice, with write enables rotated by the line index.

Test Plan:
- HRES=8, VRES=6, constant 100, Gaussian 1 2 1/2 4 2/1 2 1, shift 4 -> interior outputs 100; first data_out_valid 4 cycles after input (1,1); 35 outputs per frame.
- Same kernel, all zero except 255 at (3,3) -> centre (3,3)=63; (2,3), (4,3), (3,2), (3,4)=31; the four diagonals=15; all others 0.
- Constant 100, Gaussian -> centre (0,0)=56 (900>>4); centre (3,0)=75 (1200>>4).
- Laplacian (-1 everywhere, centre 8), shift 0, impulse 255 at (3,3) -> centre 255 (clamped from 2040); 8 neighbours 0 (clamped from -255).
- Change coeffs to all zero mid-frame -> rest of frame unchanged; next frame all outputs 0.
- Random idle cycles between valids -> identical output value/coordinate sequence. rst_in asserted mid-frame -> data_out_valid 0 the next cycle, all outputs 0.
